// File: rtl/mem_pkg.sv
// mem_pkg: memory geometry shared by the instruction memory, data memory and datapath
package mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH = 2 ** ADDR_W;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed register-array memory, synchronous write, gated combinational read
module data_memory #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [DATA_W-1:0] readdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (memwrite)
            mem[address] <= writedata;
    assign readdata = (memread && !reset) ? mem[address] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard-driven checks of write/readback, read gating, reset and boundaries
module tb_data_memory;
    logic        clk = 0;
    logic        reset = 0;
    logic [9:0]  address = '0;
    logic [31:0] writedata = '0;
    logic        memread = 0;
    logic        memwrite = 0;
    logic [31:0] readdata;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [1024];
    int          pass_cnt = 0;
    int          total = 0;

    data_memory dut (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .memread(memread), .memwrite(memwrite), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; memwrite = 1; memread = 0;
        @(posedge clk);
        #1 memwrite = 0;
        model[a] = d;
    endtask

    task automatic test_reset();
        logic [9:0] addrs [3] = '{10'h000, 10'h145, 10'h3FF};
        @(negedge clk);
        reset = 1; memread = 1; address = 10'h145;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        #1 total++;
        if (readdata !== 32'h0) $display("FAIL reset_held: got %h want 0", readdata);
        else pass_cnt++;
        @(negedge clk);
        reset = 0;
        foreach (addrs[i]) q.push_back('{addrs[i], model[addrs[i]]});
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            address = e.a; memread = 1;
            #1 total++;
            if (readdata !== e.d) $display("FAIL reset_read[%h]: got %h want %h", e.a, readdata, e.d);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_readback();
        logic [9:0]  addrs [7] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h145, 10'h305, 10'h2E0};
        logic [31:0] vals  [7] = '{32'hC00000F0, 32'h00000F00, 32'h0000F000, 32'h000F0000,
                                   32'hF0000F00, 32'h90600F00, 32'hC7030F00};
        foreach (addrs[i]) wr(addrs[i], vals[i]);
        @(negedge clk);
        foreach (addrs[i]) q.push_back('{addrs[i], vals[i]});
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            address = e.a; memread = 1; memwrite = 0;
            #1 total++;
            if (readdata !== e.d) $display("FAIL readback[%h]: got %h want %h", e.a, readdata, e.d);
            else pass_cnt++;
        end
    endtask

    task automatic test_read_gating();
        @(negedge clk);
        address = 10'h145; memread = 0;
        q.push_back('{10'h145, 32'h0});
        q.push_back('{10'h145, 32'hF0000F00});
        for (int i = 0; i < 2; i++) begin
            exp_t e = q.pop_front();
            memread = (i == 1);
            #1 total++;
            if (readdata !== e.d) $display("FAIL gating[memread=%0d]: got %h want %h", i, readdata, e.d);
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        @(negedge clk);
        address = 10'h001; writedata = 32'h12345678; memread = 1; memwrite = 1;
        q.push_back('{10'h001, model[10'h001]});
        #1 e = q.pop_front();
        total++;
        if (readdata !== e.d) $display("FAIL rw_before: got %h want %h", readdata, e.d);
        else pass_cnt++;
        model[10'h001] = 32'h12345678;
        q.push_back('{10'h001, model[10'h001]});
        @(posedge clk);
        #1 memwrite = 0;
        e = q.pop_front();
        total++;
        if (readdata !== e.d) $display("FAIL rw_after: got %h want %h", readdata, e.d);
        else pass_cnt++;
        q.push_back('{10'h002, 32'h0000F000});
        e = q.pop_front();
        address = e.a;
        #1 total++;
        if (readdata !== e.d) $display("FAIL rw_neighbour: got %h want %h", readdata, e.d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        address = 10'h3FF; writedata = 32'hDEADBEEF; memwrite = 1; memread = 1;
        #1 reset = 1;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        #1 total++;
        if (readdata !== 32'h0) $display("FAIL reset_mid_read: got %h want 0", readdata);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        memwrite = 0; reset = 0;
        foreach (model[i]) q.push_back('{i[9:0], model[i]});
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            address = e.a;
            #1 if (readdata !== e.d) bad++;
            if (e.a == 10'h2E0 || e.a == 10'h3FF) begin
                total++;
                if (readdata !== e.d) $display("FAIL reset_mid[%h]: got %h want %h", e.a, readdata, e.d);
                else pass_cnt++;
            end
        end
        total++;
        if (bad !== 0) $display("FAIL reset_sweep: got %0d nonzero words want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        wr(10'h3FF, 32'hFFFFFFFF);
        wr(10'h000, 32'hA5A5A5A5);
        @(negedge clk);
        q.push_back('{10'h3FF, 32'hFFFFFFFF});
        q.push_back('{10'h000, 32'hA5A5A5A5});
        q.push_back('{10'h3FE, 32'h0});
        q.push_back('{10'h001, 32'h0});
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            address = e.a; memread = 1;
            #1 total++;
            if (readdata !== e.d) $display("FAIL boundary[%h]: got %h want %h", e.a, readdata, e.d);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] a;
        logic [9:0] used[$];
        for (int i = 0; i < 24; i++) begin
            a = 10'($urandom_range(0, 1023));
            wr(a, $urandom);
            used.push_back(a);
        end
        @(negedge clk);
        foreach (used[i]) q.push_back('{used[i], model[used[i]]});
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            address = e.a; memread = 1;
            #1 total++;
            if (readdata !== e.d) $display("FAIL b2b[%h]: got %h want %h", e.a, readdata, e.d);
            else pass_cnt++;
        end
        memread = 0;
        #1 total++;
        if (readdata !== 32'h0) $display("FAIL b2b_idle: got %h want 0", readdata);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_read_gating();
        test_simultaneous();
        test_reset_mid();
        test_boundary();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
